adam_mem_ctrl: RTL
==================

// Module: adam_mem_ctrl
// PURPOSE
// - Upstream front-end for the single-port byte-enable SRAM (adam_mem). Accepts valid/ready
//   requests, drives the raw SRAM port, captures read data one cycle after issue and returns
//   in-order responses through a small buffer. A stalled requester never loses data.
// - Gates SRAM writes: the SRAM writes whenever mem_we=1, so mem_we must only be high on an issued write.
// - Range check: addresses >= SIZE never reach the SRAM and are answered with rsp_err.
// PARAMETERS
// - ADAM_CFG_PARAMS  (cfg)  ADDR_WIDTH/DATA_WIDTH/STRB_WIDTH, ADDR_T/DATA_T/STRB_T
// - SIZE             4096   SRAM size in bytes; must match the attached adam_mem
// - RSP_DEPTH        2      response buffer entries, >= 2
// PORTS
// - seq.clk      in   1           clock, ADAM_SEQ.Slave seq
// - seq.rst      in   1           reset, asynchronous, active-low (0 = in reset)
// - req_valid    in   1           request valid
// - req_ready    out  1           request accepted when valid&ready
// - req_addr     in   ADDR_WIDTH  byte address (low $clog2(STRB_WIDTH) bits ignored)
// - req_we       in   1           1 = write
// - req_be       in   STRB_WIDTH  byte enables (writes only)
// - req_wdata    in   DATA_WIDTH  write data
// - rsp_valid    out  1           response valid
// - rsp_ready    in   1           response consumed when valid&ready
// - rsp_rdata    out  DATA_WIDTH  read data; 0 for writes and errors
// - rsp_err      out  1           1 = address out of range
// - mem_req/mem_addr/mem_we/mem_be/mem_wdata  out  to SRAM;  mem_rdata  in  DATA_WIDTH
// BEHAVIOUR
// - Reset (seq.rst=0, async): buffer empty, inflight=0, rsp_valid=0, req_ready=0,
//   rsp_rdata=0, rsp_err=0, mem_req=0, mem_we=0. Transactions in flight are dropped.
// - accept = req_valid & req_ready. in_range = req_addr < SIZE.
// - Issue (cycle T): if accept&in_range, mem_req=1 and mem_we=req_we. All mem_* signals are
//   combinational from req_*. Otherwise mem_req=0 and mem_we=0; mem_addr/be/wdata are don't-care.
// - Capture (cycle T+1): inflight register {valid, we, err} set on accept. At T+1 push one entry:
//   rdata = (!we & !err) ? mem_rdata : 0, err = err. mem_rdata is only meaningful at T+1;
//   the SRAM updates it every cycle.
// - Response: FIFO head drives rsp_*. rsp_valid = !empty. Pop on rsp_valid&rsp_ready.
//   Minimum latency accept->rsp_valid is 2 cycles (T+2). Responses are strictly in order.
// - Flow control: req_ready = seq.rst & ((count + inflight - pop) < RSP_DEPTH).
//   This is a combinational path from rsp_ready to req_ready.
//   Sustained 1 req/cycle when rsp_ready is held 1. Never overflows; push is never refused.
// - Simultaneous push and pop: both take effect and count is unchanged. Pop of the last entry
//   plus push in the same cycle makes rsp_valid stay 1 with the new head.
// - Full buffer with rsp_ready=0: req_ready=0, no SRAM access, all state held.
// - Counters: count is $clog2(RSP_DEPTH+1) bits. Read/write pointers wrap modulo RSP_DEPTH.
// - Error requests consume a buffer slot exactly like good ones and never toggle mem_req.
// - A write response is returned after the SRAM write edge (T+1), so a following read returns the new data.
// STRUCTURE
// - Shared package (adam pkg / macros): typedef struct packed {DATA_T rdata; logic err;} MEM_RSP_T.
// - Sub-module adam_mem_rsp_fifo: parameterised RSP_DEPTH x MEM_RSP_T FIFO.
//   Outputs count/empty, async active-low reset; push/pop in the same cycle are allowed.
// - Top level: inflight register, range compare, req_ready logic, mem_* gating.
// TESTING
// - Reset mid-burst: 2 reads accepted, seq.rst=0 at T+1 -> rsp_valid=0, mem_we=0 and
//   req_ready=0 immediately; after release, no stale responses.
// - Write/read: write addr 0x10 be=4'b0101 wdata=0xAABBCCDD over 0x11223344 ->
//   rsp_err=0, rdata=0; then read 0x10 -> rsp_rdata=0x11BB33DD at T+2.
// - Streaming: 16 back-to-back reads with rsp_ready=1 -> req_ready stays 1, 16 in-order
//   responses on consecutive cycles, first at T+2.
// - Backpressure: rsp_ready=0 -> exactly RSP_DEPTH(2) accepted, then req_ready=0 and
//   mem_req=0; mem_rdata toggling meanwhile does not corrupt buffered data.
//   Release -> responses drain in order.
// - Range: read 0x1000 (SIZE=4096) -> mem_req never 1, rsp_err=1, rsp_rdata=0.
//   Write 0x2000 -> mem_we never 1, SRAM contents unchanged.
// - Wrap: 10 pushes with pops interleaved 1-in-3 -> pointers wrap, order and data intact, count returns to 0.

Source files
------------

// File: rtl/adam_mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// adam_mem_ctrl_pkg
// Shared widths, types and helpers for the adam_mem_ctrl front-end.
//   addr_t / data_t / strb_t : request address, data word and byte-enable types
//   mem_rsp_t                : one buffered response {rdata, err}
//   addr_in_range()          : byte address below the attached SRAM size
//   word_align()             : clear the byte-offset bits of an address
// -----------------------------------------------------------------------------
package adam_mem_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;

    typedef struct packed {
        data_t rdata;
        logic  err;
    } mem_rsp_t;

    function automatic logic addr_in_range(input addr_t addr, input int unsigned size);
        return (32'(addr) < size);
    endfunction

    // The SRAM works on whole words, so the byte offset is dropped on the way out.
    function automatic addr_t word_align(input addr_t addr);
        return addr & ~addr_t'(STRB_WIDTH - 32'd1);
    endfunction

endpackage

// File: rtl/adam_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// adam_mem_ctrl_if
// Request/response handshake bundle between a requester and adam_mem_ctrl.
//   req_valid/req_ready/req_addr/req_we/req_be/req_wdata : request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                : response channel
// Modports: master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface adam_mem_ctrl_if;
    import adam_mem_ctrl_pkg::*;

    logic  req_valid;
    logic  req_ready;
    addr_t req_addr;
    logic  req_we;
    strb_t req_be;
    data_t req_wdata;
    logic  rsp_valid;
    logic  rsp_ready;
    data_t rsp_rdata;
    logic  rsp_err;

    modport master (
        output req_valid, req_addr, req_we, req_be, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_be, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/adam_mem_ctrl_rsp_fifo.sv
// -----------------------------------------------------------------------------
// adam_mem_ctrl_rsp_fifo
// DEPTH-entry FIFO of mem_rsp_t holding completed responses in order.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (clears all entries)
//   i_push, i_data : write one entry (ignored only if full with no pop)
//   i_pop          : remove head entry (ignored when empty)
//   o_data         : head entry
//   o_count        : number of stored entries, o_empty : count == 0
// Push and pop in the same cycle both take effect and leave count unchanged.
// -----------------------------------------------------------------------------
module adam_mem_ctrl_rsp_fifo
    import adam_mem_ctrl_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 32'd1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  mem_rsp_t         i_data,
    input  logic             i_pop,
    output mem_rsp_t         o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    mem_rsp_t         r_mem [DEPTH];
    logic             w_push_en;
    logic             w_pop_en;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 32'd1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1'b1);
        end
    endfunction

    // Qualify push/pop against the current fill level and expose the head.
    always_comb begin
        w_pop_en  = i_pop & (r_count != {CNT_W{1'b0}});
        w_push_en = i_push & ((r_count != CNT_W'(DEPTH)) | w_pop_en);
        o_empty   = (r_count == {CNT_W{1'b0}});
        o_count   = r_count;
        o_data    = r_mem[r_rd_ptr];
    end

    // Storage, pointers and occupancy counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            for (int unsigned i = 32'd0; i < DEPTH; i++) begin
                r_mem[i] <= '{rdata: {DATA_WIDTH{1'b0}}, err: 1'b0};
            end
        end else begin
            if (w_push_en) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_next(r_wr_ptr);
            end
            if (w_pop_en) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + CNT_W'(1'b1);
                2'b01:   r_count <= r_count - CNT_W'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/adam_mem_ctrl.sv
// -----------------------------------------------------------------------------
// adam_mem_ctrl
// Valid/ready front-end for a single-port byte-enable SRAM (adam_mem).
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   bus (slave modport)  : request and response handshake channels
//   o_mem_req/o_mem_addr/o_mem_we/o_mem_be/o_mem_wdata : raw SRAM port
//   i_mem_rdata          : SRAM read data, valid the cycle after a read issue
// A request is issued to the SRAM in its accept cycle, its read data is
// captured one cycle later and queued; responses come back in order.
// Requests at or above SIZE never touch the SRAM and return rsp_err=1.
// -----------------------------------------------------------------------------
module adam_mem_ctrl
    import adam_mem_ctrl_pkg::*;
#(
    parameter  int unsigned SIZE      = 4096,
    parameter  int unsigned RSP_DEPTH = 2,
    localparam int unsigned CNT_W     = $clog2(RSP_DEPTH + 32'd1),
    localparam int unsigned OCC_W     = CNT_W + 32'd1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    adam_mem_ctrl_if.slave  bus,
    output logic            o_mem_req,
    output addr_t           o_mem_addr,
    output logic            o_mem_we,
    output strb_t           o_mem_be,
    output data_t           o_mem_wdata,
    input  data_t           i_mem_rdata
);

    logic             r_inf_valid;
    logic             r_inf_we;
    logic             r_inf_err;
    logic             w_in_range;
    logic             w_accept;
    logic             w_pop;
    logic             w_req_ready;
    logic [OCC_W-1:0] w_occ;
    logic [CNT_W-1:0] w_count;
    logic             w_empty;
    mem_rsp_t         w_push_data;
    mem_rsp_t         w_head;

    // Slot accounting: a slot is reserved for the request in flight, and a
    // slot being popped this cycle is already free. Reset forces ready low.
    always_comb begin
        w_in_range  = addr_in_range(bus.req_addr, SIZE);
        w_pop       = ~w_empty & bus.rsp_ready;
        w_occ       = {1'b0, w_count}
                    + {{CNT_W{1'b0}}, r_inf_valid}
                    - {{CNT_W{1'b0}}, w_pop};
        w_req_ready = i_rst_n & (w_occ < OCC_W'(RSP_DEPTH));
        w_accept    = bus.req_valid & w_req_ready;
    end

    assign bus.req_ready = w_req_ready;

    // SRAM port: strobe and write enable only for an accepted in-range request.
    always_comb begin
        o_mem_req   = w_accept & w_in_range;
        o_mem_we    = o_mem_req & bus.req_we;
        o_mem_addr  = word_align(bus.req_addr);
        o_mem_be    = bus.req_be;
        o_mem_wdata = bus.req_wdata;
    end

    // Remember what was issued so the next cycle knows how to build its response.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inf_valid <= 1'b0;
            r_inf_we    <= 1'b0;
            r_inf_err   <= 1'b0;
        end else begin
            r_inf_valid <= w_accept;
            r_inf_we    <= bus.req_we;
            r_inf_err   <= ~w_in_range;
        end
    end

    // mem_rdata is only meaningful for a good read; everything else returns zero.
    always_comb begin
        w_push_data.err = r_inf_err;
        if (!r_inf_we && !r_inf_err) begin
            w_push_data.rdata = i_mem_rdata;
        end else begin
            w_push_data.rdata = {DATA_WIDTH{1'b0}};
        end
    end

    adam_mem_ctrl_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (r_inf_valid),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    // Head of the buffer drives the response; an empty buffer shows zeros.
    always_comb begin
        bus.rsp_valid = ~w_empty;
        if (w_empty) begin
            bus.rsp_rdata = {DATA_WIDTH{1'b0}};
            bus.rsp_err   = 1'b0;
        end else begin
            bus.rsp_rdata = w_head.rdata;
            bus.rsp_err   = w_head.err;
        end
    end

endmodule
